// File: rtl/instr_encoder.sv
// Instruction encoder and program loader: packs one symbolic instruction per handshake
// into a MIPS-format word and streams it into instruction memory at an auto-incrementing address.
module instr_encoder #(
    parameter int          ADDR_W = 10,
    parameter logic [31:0] BASE   = 32'h0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              restart,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op,
    input  logic [5:0]        opc_in,
    input  logic [5:0]        fn,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        sa,
    input  logic [31:0]       imm32,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_EMIT2 = 1'b1;

    localparam logic [3:0] OP_R    = 4'd0;
    localparam logic [3:0] OP_I    = 4'd1;
    localparam logic [3:0] OP_LW   = 4'd2;
    localparam logic [3:0] OP_SW   = 4'd3;
    localparam logic [3:0] OP_BR   = 4'd4;
    localparam logic [3:0] OP_J    = 4'd5;
    localparam logic [3:0] OP_JAL  = 4'd6;
    localparam logic [3:0] OP_LI   = 4'd7;
    localparam logic [3:0] OP_NOP  = 4'd8;

    localparam logic [1:0] E_NONE  = 2'd0;
    localparam logic [1:0] E_OP    = 2'd1;
    localparam logic [1:0] E_RANGE = 2'd2;
    localparam logic [1:0] E_OVF   = 2'd3;

    localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [0:0]         state;
    logic [31:0]        pend_word;

    logic [ADDR_W-1:0]  ptr;
    logic [ADDR_W:0]    count_inc;
    logic [ADDR_W:0]    room;
    logic [31:0]        pc;
    logic [31:0]        pc4;
    logic [31:0]        br_diff;
    logic signed [31:0] off;
    logic               off_ok;
    logic               j_ok;
    logic               li_two;
    logic [1:0]         nwords;
    logic               overflow;
    logic               accept;

    logic [31:0]        word0;
    logic [31:0]        word1;
    logic [1:0]         code;

    assign ptr       = count[ADDR_W-1:0];
    assign count_inc = count + ONE;
    assign room      = CAP - count;
    assign pc        = BASE + {{(30-ADDR_W){1'b0}}, ptr, 2'b00};
    assign pc4       = pc + 32'd4;

    // Branch offset is measured from the delay-slot address, with 32-bit wrap-around.
    assign br_diff   = imm32 - pc4;
    assign off       = $signed(br_diff) >>> 2;
    assign off_ok    = (&off[31:15]) | ~(|off[31:15]);
    assign j_ok      = (imm32[1:0] == 2'b00) && (imm32[31:28] == pc4[31:28]);

    assign li_two    = |imm32[31:16];
    assign nwords    = (op == OP_LI && li_two) ? 2'd2 : 2'd1;
    assign overflow  = {{(ADDR_W-1){1'b0}}, nwords} > room;

    assign in_ready  = (state == S_IDLE) && !full && !restart;
    assign accept    = in_valid && in_ready;

    // NOTE: every variable in this block gets a default first so no latch is inferred.
    always_comb begin
        word0 = 32'h0;
        word1 = 32'h0;
        code  = E_NONE;
        case (op)
            OP_R:   word0 = {6'b000000, rs, rt, rd, sa, fn};
            OP_I:   word0 = {opc_in, rs, rt, imm32[15:0]};
            OP_LW:  word0 = {6'b100011, rs, rt, imm32[15:0]};
            OP_SW:  word0 = {6'b101011, rs, rt, imm32[15:0]};
            OP_BR: begin
                word0 = {opc_in, rs, rt, off[15:0]};
                if (imm32[1:0] != 2'b00 || !off_ok) code = E_RANGE;
            end
            OP_J, OP_JAL: begin
                word0 = {(op == OP_J) ? 6'b000010 : 6'b000011, imm32[27:2]};
                if (!j_ok) code = E_RANGE;
            end
            OP_LI: begin
                if (li_two) begin
                    word0 = {6'b001111, 5'd0, rt, imm32[31:16]};
                    word1 = {6'b001101, rt, rt, imm32[15:0]};
                end else begin
                    word0 = {6'b001101, 5'd0, rt, imm32[15:0]};
                end
            end
            OP_NOP: word0 = 32'h0;
            default: code = E_OP;
        endcase
        if (code == E_NONE && overflow) code = E_OVF;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pend_word <= 32'h0;
            im_we     <= 1'b0;
            im_addr   <= '0;
            im_wdata  <= 32'h0;
            count     <= '0;
            full      <= 1'b0;
            err       <= 1'b0;
            err_code  <= E_NONE;
        end else begin
            im_we <= 1'b0;
            err   <= 1'b0;
            if (restart) begin
                state    <= S_IDLE;
                count    <= '0;
                full     <= 1'b0;
                err_code <= E_NONE;
            end else if (state == S_EMIT2) begin
                im_we    <= 1'b1;
                im_addr  <= ptr;
                im_wdata <= pend_word;
                count    <= count_inc;
                full     <= (count_inc == CAP);
                state    <= S_IDLE;
            end else if (accept) begin
                if (code != E_NONE) begin
                    err      <= 1'b1;
                    err_code <= code;
                end else begin
                    err_code <= E_NONE;
                    im_we    <= 1'b1;
                    im_addr  <= ptr;
                    im_wdata <= word0;
                    count    <= count_inc;
                    full     <= (count_inc == CAP);
                    if (nwords == 2'd2) begin
                        state     <= S_EMIT2;
                        pend_word <= word1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus randomized traffic,
// compared every cycle against a queue-based reference model of the loader.
module tb_instr_encoder;

    localparam int          ADDR_W = 3;
    localparam int          CAP    = 1 << ADDR_W;
    localparam logic [31:0] BASE   = 32'h0;

    logic              clk;
    logic              rst_n;
    logic              restart;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        op;
    logic [5:0]        opc_in;
    logic [5:0]        fn;
    logic [4:0]        rs, rt, rd, sa;
    logic [31:0]       imm32;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              err;
    logic [1:0]        err_code;

    instr_encoder #(.ADDR_W(ADDR_W), .BASE(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .restart(restart),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .opc_in(opc_in), .fn(fn),
        .rs(rs), .rt(rt), .rd(rd), .sa(sa), .imm32(imm32),
        .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .count(count), .full(full), .err(err), .err_code(err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: words still owed to memory sit in a queue.
    logic [31:0] pend[$];
    int          m_cnt;
    logic        m_we, m_err, m_full;
    logic [31:0] m_addr, m_wdata;
    logic [1:0]  m_code;

    function automatic void m_reset();
        pend.delete();
        m_cnt = 0; m_we = 0; m_err = 0; m_full = 0;
        m_addr = 0; m_wdata = 0; m_code = 0;
    endfunction

    function automatic logic m_ready();
        return (pend.size() == 0) && !m_full && !restart;
    endfunction

    function automatic void m_write(input logic [31:0] w);
        m_we = 1; m_addr = m_cnt; m_wdata = w; m_cnt++;
    endfunction

    function automatic void m_encode(input int pc, output int n, output logic [31:0] w0,
                                     output logic [31:0] w1, output logic [1:0] code);
        int          d, offv;
        logic [31:0] pc4, hi, lo;
        n = 1; w0 = 0; w1 = 0; code = 0;
        hi = imm32 >> 16;
        lo = imm32 & 32'hFFFF;
        pc4 = pc + 4;
        case (op)
            0: w0 = (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | (32'(sa) << 6) | 32'(fn);
            1: w0 = (32'(opc_in) << 26) | (32'(rs) << 21) | (32'(rt) << 16) | lo;
            2: w0 = (32'd35 << 26) | (32'(rs) << 21) | (32'(rt) << 16) | lo;
            3: w0 = (32'd43 << 26) | (32'(rs) << 21) | (32'(rt) << 16) | lo;
            4: begin
                d = int'(imm32) - pc - 4;
                offv = d / 4;
                if (imm32 % 4 != 0 || offv < -32768 || offv > 32767) code = 2;
                w0 = (32'(opc_in) << 26) | (32'(rs) << 21) | (32'(rt) << 16) | (32'(offv) & 32'hFFFF);
            end
            5, 6: begin
                if (imm32 % 4 != 0 || (imm32 >> 28) != (pc4 >> 28)) code = 2;
                w0 = ((op == 5 ? 32'd2 : 32'd3) << 26) | ((imm32 >> 2) & 32'h03FF_FFFF);
            end
            7: begin
                if (hi != 0) begin
                    n  = 2;
                    w0 = (32'd15 << 26) | (32'(rt) << 16) | hi;
                    w1 = (32'd13 << 26) | (32'(rt) << 21) | (32'(rt) << 16) | lo;
                end else begin
                    w0 = (32'd13 << 26) | (32'(rt) << 16) | lo;
                end
            end
            8: w0 = 0;
            default: code = 1;
        endcase
        if (code == 0 && n > CAP - m_cnt) code = 3;
    endfunction

    // Advances the model across one rising edge using the inputs presented before it.
    function automatic void m_step();
        int          n;
        logic [31:0] w0, w1;
        logic [1:0]  code;
        logic        rdy;
        rdy = m_ready();
        m_we = 0; m_err = 0;
        if (restart) begin
            pend.delete(); m_cnt = 0; m_code = 0;
        end else if (pend.size() != 0) begin
            m_write(pend.pop_front());
        end else if (in_valid && rdy) begin
            m_encode(int'(BASE) + 4 * m_cnt, n, w0, w1, code);
            if (code != 0) begin
                m_err = 1; m_code = code;
            end else begin
                m_code = 0;
                m_write(w0);
                if (n == 2) pend.push_back(w1);
            end
        end
        m_full = (m_cnt == CAP);
    endfunction

    task automatic check_outputs();
        check("im_we", im_we, m_we);
        check("im_addr", im_addr, m_addr);
        check("im_wdata", im_wdata, m_wdata);
        check("count", count, m_cnt);
        check("full", full, m_full);
        check("err", err, m_err);
        check("err_code", err_code, m_code);
    endtask

    // Called at a falling edge after inputs are driven; returns at the next falling edge.
    task automatic cycle();
        #1;
        check("in_ready", in_ready, m_ready());
        m_step();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic req(input logic [3:0] o, input logic [4:0] s, input logic [4:0] t,
                       input logic [4:0] d, input logic [4:0] a, input logic [5:0] f,
                       input logic [5:0] oc, input logic [31:0] im);
        in_valid = 1; restart = 0;
        op = o; rs = s; rt = t; rd = d; sa = a; fn = f; opc_in = oc; imm32 = im;
        cycle();
    endtask

    task automatic idle();
        in_valid = 0; restart = 0;
        cycle();
    endtask

    task automatic do_restart();
        in_valid = 0; restart = 1;
        cycle();
        restart = 0;
    endtask

    task automatic random_cycle();
        int pcn, k;
        restart  = ($urandom_range(0, 39) == 0);
        in_valid = ($urandom_range(0, 4) != 0);
        op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
        rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); sa = 5'($urandom);
        fn = 6'($urandom); opc_in = 6'($urandom); imm32 = $urandom;
        pcn = int'(BASE) + 4 * m_cnt;
        if (op == 1) opc_in = 6'(8 + $urandom_range(0, 7));
        if (op == 4) begin
            opc_in = 6'($urandom_range(0, 3) == 0 ? 1 : 4 + $urandom_range(0, 3));
            k = $urandom_range(0, 3);
            case (k)
                0: imm32 = pcn + 4 + 4 * (int'($urandom_range(0, 200)) - 100);
                1: imm32 = pcn + 4 + 4 * (32767 + int'($urandom_range(0, 1)));
                2: imm32 = pcn + 4 - 4 * (32768 + int'($urandom_range(0, 1)));
                default: imm32 = pcn + 4 * int'($urandom_range(0, 20)) + 2;
            endcase
        end
        if (op == 5 || op == 6)
            imm32 = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0FFF_FFFC);
        if (op == 7 && $urandom_range(0, 1) == 0) imm32 = imm32 & 32'hFFFF;
        cycle();
    endtask

    initial begin
        rst_n = 0; restart = 0; in_valid = 0;
        op = 0; opc_in = 0; fn = 0; rs = 0; rt = 0; rd = 0; sa = 0; imm32 = 0;
        m_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        check_outputs();
        check("reset_in_ready", in_ready, 1);

        // R-ALU add $3,$1,$2
        req(0, 1, 2, 3, 0, 6'h20, 0, 0);
        check("r_word", im_wdata, 32'h00221820);
        check("r_count", count, 1);
        do_restart();

        // Two-word LI, then one-word LI held valid through the EMIT2 cycle.
        req(7, 0, 8, 0, 0, 0, 0, 32'h12345678);
        check("lui_word", im_wdata, 32'h3C081234);
        check("li_ready_low", in_ready, 0);
        req(7, 0, 8, 0, 0, 0, 0, 32'h0000ABCD);
        check("ori_word", im_wdata, 32'h35085678);
        check("ori_addr", im_addr, 1);
        req(7, 0, 8, 0, 0, 0, 0, 32'h0000ABCD);
        check("li1_word", im_wdata, 32'h3408ABCD);
        check("li1_addr", im_addr, 2);
        do_restart();

        // Branch offsets and the +/- range boundaries.
        for (int i = 0; i < 4; i++) req(8, 0, 0, 0, 0, 0, 0, 0);
        req(4, 1, 2, 0, 0, 0, 6'h04, 32'h0);
        check("br_word", im_wdata, 32'h1022FFFB);
        req(4, 1, 2, 0, 0, 0, 6'h04, 32'h00020018);
        check("br_far_err", err, 1);
        check("br_far_code", err_code, 2);
        check("br_far_count", count, 5);
        req(4, 1, 2, 0, 0, 0, 6'h04, 32'h00020014);
        check("br_max", im_wdata, 32'h10227FFF);
        req(4, 1, 2, 0, 0, 0, 6'h04, 32'hFFFE001C);
        check("br_min", im_wdata, 32'h10228000);
        req(4, 1, 2, 0, 0, 0, 6'h04, 32'hFFFE0018);
        check("br_low_err", err_code, 2);
        do_restart();

        // Jumps.
        req(5, 0, 0, 0, 0, 0, 0, 32'h40);
        check("j_word", im_wdata, 32'h08000010);
        req(6, 0, 0, 0, 0, 0, 0, 32'h40);
        check("jal_word", im_wdata, 32'h0C000010);
        req(5, 0, 0, 0, 0, 0, 0, 32'h42);
        check("j_align_code", err_code, 2);
        check("j_align_we", im_we, 0);
        req(5, 0, 0, 0, 0, 0, 0, 32'h10000000);
        check("j_region_code", err_code, 2);
        do_restart();

        // Overflow, full, restart.
        for (int i = 0; i < CAP - 1; i++) req(8, 0, 0, 0, 0, 0, 0, 0);
        req(7, 0, 9, 0, 0, 0, 0, 32'h00010001);
        check("ovf_code", err_code, 3);
        check("ovf_count", count, CAP - 1);
        req(8, 0, 0, 0, 0, 0, 0, 0);
        check("full_count", count, CAP);
        check("full_flag", full, 1);
        check("full_ready", in_ready, 0);
        req(8, 0, 0, 0, 0, 0, 0, 0);
        do_restart();
        in_valid = 0;
        #1;
        check("restart_ready", in_ready, 1);
        check("restart_count", count, 0);
        idle();

        // Restart during EMIT2 aborts the second word and beats a valid request.
        req(7, 0, 3, 0, 0, 0, 0, 32'hDEAD0001);
        in_valid = 1; restart = 1;
        cycle();
        check("abort_we", im_we, 0);
        restart = 0;
        idle();

        // Asynchronous reset during EMIT2.
        req(7, 0, 8, 0, 0, 0, 0, 32'h12345678);
        in_valid = 0;
        #1 rst_n = 0;
        #1;
        m_reset();
        check_outputs();
        check("arst_ready", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        check_outputs();
        rst_n = 1;
        idle();
        check("arst_no_ori", im_we, 0);

        // Illegal op.
        req(12, 0, 0, 0, 0, 0, 0, 0);
        check("illegal_code", err_code, 1);
        check("illegal_we", im_we, 0);
        idle();

        for (int i = 0; i < 3000; i++) random_cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
